// File: rtl/mandel_iter_engine.sv
// Fixed-point Mandelbrot iteration engine: z <- z^2 + c at one iteration per clock, start/busy/done handshake.
// Optional Julia mode (julia, in_sel_c ports and jx/jy constants) is built when MANDEL_JULIA_EN is defined.

module mandel_iter_engine #(
    parameter int INT_BITS  = 2,
    parameter int FRAC_BITS = 12,
    parameter int ITER_BITS = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INT_BITS+FRAC_BITS-1:0] in_value,
    input  logic                          in_sel_x,
    input  logic                          in_en,
    input  logic                          start,
    input  logic [ITER_BITS-1:0]          max_iter,
`ifdef MANDEL_JULIA_EN
    input  logic                          julia,
    input  logic                          in_sel_c,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          escaped,
    output logic [ITER_BITS-1:0]          iter
);

    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int ZW = W + 2;
    localparam int PW = 2 * ZW;
    localparam logic signed [PW:0] MAG_LIMIT = (PW + 1)'(4) <<< FRAC_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                state;
    logic signed [ZW-1:0]  cx, cy, zx, zy;
    logic signed [ZW-1:0]  cx_nxt, cy_nxt, add_x, add_y, z0x, z0y;
    logic [ITER_BITS-1:0]  max_lat;
    logic signed [ZW-1:0]  in_ext;
    logic                  load_ok, load_c;

    logic signed [PW-1:0]  zx_w, zy_w, sq_x, sq_y, xy_prod;
    logic signed [PW:0]    xy2, mag;
    logic signed [ZW-1:0]  zx_upd, zy_upd;

    assign in_ext  = $signed({{(ZW - W){in_value[W-1]}}, in_value});
    assign load_ok = in_en && (state != S_ITER);

`ifdef MANDEL_JULIA_EN
    logic signed [ZW-1:0] jx, jy, jx_nxt, jy_nxt;
    logic                 julia_mode, load_j;

    assign load_c = load_ok && !in_sel_c;
    assign load_j = load_ok && in_sel_c;
    assign add_x  = julia_mode ? jx : cx;
    assign add_y  = julia_mode ? jy : cy;
    // Julia runs seed z with the stored point, including a load issued alongside start.
    assign z0x    = julia ? cx_nxt : '0;
    assign z0y    = julia ? cy_nxt : '0;

    always_comb begin
        jx_nxt = jx;
        jy_nxt = jy;
        if (load_j) begin
            if (in_sel_x) jx_nxt = in_ext;
            else          jy_nxt = in_ext;
        end
    end
`else
    assign load_c = load_ok;
    assign add_x  = cx;
    assign add_y  = cy;
    assign z0x    = '0;
    assign z0y    = '0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cx_nxt = cx;
        cy_nxt = cy;
        if (load_c) begin
            if (in_sel_x) cx_nxt = in_ext;
            else          cy_nxt = in_ext;
        end
    end

    // Exact double-width products, floored back to FRAC_BITS; escape is tested before z is updated.
    assign zx_w    = PW'(zx);
    assign zy_w    = PW'(zy);
    assign sq_x    = (zx_w * zx_w) >>> FRAC_BITS;
    assign sq_y    = (zy_w * zy_w) >>> FRAC_BITS;
    assign xy_prod = zx_w * zy_w;
    assign xy2     = $signed({xy_prod, 1'b0});
    assign mag     = (PW + 1)'(sq_x) + (PW + 1)'(sq_y);
    assign zx_upd  = ZW'(sq_x - sq_y + PW'(add_x));
    assign zy_upd  = ZW'((xy2 >>> FRAC_BITS) + (PW + 1)'(add_y));

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is reset, including the stored point; there is no memory array.
            state   <= S_IDLE;
            cx      <= '0;
            cy      <= '0;
            zx      <= '0;
            zy      <= '0;
            max_lat <= '0;
            iter    <= '0;
            escaped <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MANDEL_JULIA_EN
            jx         <= '0;
            jy         <= '0;
            julia_mode <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            cx   <= cx_nxt;
            cy   <= cy_nxt;
`ifdef MANDEL_JULIA_EN
            jx <= jx_nxt;
            jy <= jy_nxt;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        zx      <= z0x;
                        zy      <= z0y;
                        iter    <= '0;
                        escaped <= 1'b0;
                        max_lat <= max_iter;
                        busy    <= 1'b1;
                        state   <= S_ITER;
`ifdef MANDEL_JULIA_EN
                        julia_mode <= julia;
`endif
                    end
                end
                S_ITER: begin
                    if (mag >= MAG_LIMIT) begin
                        escaped <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else if (iter == max_lat) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        zx   <= zx_upd;
                        zy   <= zy_upd;
                        iter <= iter + ITER_BITS'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mandel_iter_engine.md
Name: mandel_iter_engine

Overview:
- Parametrised successor to the single-point Mandelbrot core.
- Stores a complex point in signed fixed-point, then runs z <- z^2 + c at one iteration per clock.
- Reports the iteration count and an escaped flag through a start/busy/done handshake.
- Generalised over value width, fraction bits, iteration-counter width and a runtime iteration limit; adds an optional Julia mode. Sits behind the top-level pin mapper, which packs escaped and iter onto outputs.

Parameters:
- INT_BITS, 2, integer bits of loaded values including sign (range [-2^(INT_BITS-1), 2^(INT_BITS-1))).
- FRAC_BITS, 12, fraction bits; loaded value width W = INT_BITS+FRAC_BITS.
- ITER_BITS, 7, width of iteration counter and max_iter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_value  in  W  signed fixed-point load value.
- in_sel_x  in  1  load target: 1 = real part (cx), 0 = imaginary part (cy).
- in_en  in  1  load strobe.
- start  in  1  begin iteration on the stored point.
- max_iter  in  ITER_BITS  iteration limit, sampled on the accepted start.
- busy  out  1  high in ITER state.
- done  out  1  one-cycle pulse when a result is valid.
- escaped  out  1  1 = |z|^2 reached 4.0.
- iter  out  ITER_BITS  iterations completed.

Behaviour:
- Reset, asynchronous: state=IDLE; cx, cy, zx, zy, iter, escaped, busy, done all 0.
- Internal zx/zy are ZW = W+2 bits with the same FRAC_BITS (4 integer bits at default).
- Loaded values are sign-extended into ZW.
- Loads: in_en in IDLE or DONE writes in_value to cx (in_sel_x=1) or cy (in_sel_x=0). in_en in ITER is ignored.
- FSM states: IDLE -> ITER -> DONE -> IDLE.
- IDLE, start=1: zx=zy=0, iter=0, escaped=0, max_iter latched, busy=1, next state ITER.
  - A load in the same cycle as start is applied and used by this run.
- ITER, one evaluation per cycle:
  - Squares and products are exact 2*ZW-bit, then arithmetic-shifted right by FRAC_BITS (floor).
  - mag = zx^2 + zy^2, compared at full width (no truncation).
  - If mag >= 4.0: escaped=1, iter held, next state DONE.
  - Else if iter == latched max_iter: escaped=0, next state DONE.
  - Else: zx <= zx^2 - zy^2 + cx; zy <= 2*zx*zy + cy; iter <= iter+1.
  - No overflow is possible: escape is checked before every update, so |z| < 2 feeds every square.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- escaped and iter hold until the next accepted start.
- Latency: done is high in the cycle after clock edge n+2 counted from the start edge, where n is the final iter. Total run occupies n+1 ITER cycles.
- start in ITER or DONE is ignored.
- max_iter=0: a single evaluation, then done with iter=0; escaped=1 only if c... z0 has mag >= 4, so escaped=0.
- Reset mid-run aborts to IDLE immediately; cx and cy are cleared; no done pulse.

Optional Feature:
- Macro: MANDEL_JULIA_EN.
- With the macro defined:
  - Adds input julia (1 bit) and input in_sel_c (1 bit).
  - in_en with in_sel_c=1 writes the constant jx (in_sel_x=1) or jy (in_sel_x=0) instead of cx/cy.
  - jx and jy reset to 0.
  - If julia=1 on the start cycle: z0 = (cx, cy) and the update adds (jx, jy) in place of (cx, cy).
  - julia=0 behaves exactly as without the macro.
- Without the macro: both ports are absent; Mandelbrot mode only.

Test Plan:
- Reset mid-run: reset asserted during ITER -> busy=0, done=0, iter=0, escaped=0 asynchronously; next run on cx=cy=0 with max_iter=127 -> iter=127, escaped=0, done at start edge +129.
- cx=1.0 (0x1000), cy=0, max_iter=127 -> z sequence 0, 1, 2; escaped=1, iter=2; done at start edge +4.
- cx=-2.0 (0x2000), cy=0 -> escaped=1, iter=1. cx=-1.0 (0x3000), cy=0, max_iter=20 -> periodic orbit; escaped=0, iter=20.
- Loads while busy and restarts: in_en with a new cx while busy, plus a second start mid-run -> both ignored, result unchanged. max_iter=0 -> done at start edge +2, iter=0, escaped=0.
- Same-cycle load and start: cx=1.0 applied with start -> result iter=2, escaped=1. done is exactly one cycle wide; busy never overlaps done.
- Julia mode (MANDEL_JULIA_EN): z0=(0,0), j=(1.0,0), julia=1 -> iter=2, escaped=1. z0=(1.5,0), j=(0,0) -> 1.5, 2.25; escaped=1, iter=1.
